// File: rtl/efferent_weight_scheduler_if.sv
// Spike, host-config, matrix-port and synaptic-event bundle
// for the efferent weight scheduler.
interface efferent_weight_scheduler_if #(
  parameter int TAG_W    = 1,
  parameter int WEIGHT_W = 17
);
  logic                spike_valid;
  logic [TAG_W-1:0]    spike_tag;
  logic                spike_ready;
  logic                cfg_valid;
  logic [TAG_W-1:0]    cfg_src;
  logic [TAG_W-1:0]    cfg_dst;
  logic [WEIGHT_W-1:0] cfg_weight;
  logic                cfg_ready;
  logic [TAG_W-1:0]    wm_src_tag;
  logic [TAG_W-1:0]    wm_dst_tag;
  logic                wm_write_en;
  logic [WEIGHT_W-1:0] wm_weight_in;
  logic [WEIGHT_W-1:0] wm_weight_out;
  logic                syn_valid;
  logic [TAG_W-1:0]    syn_dst;
  logic [WEIGHT_W-1:0] syn_weight;
  logic                scan_done;
  logic                busy;

  modport master (
    output spike_valid, spike_tag,
    output cfg_valid, cfg_src, cfg_dst,
    output cfg_weight, wm_weight_out,
    input  spike_ready, cfg_ready,
    input  wm_src_tag, wm_dst_tag,
    input  wm_write_en, wm_weight_in,
    input  syn_valid, syn_dst, syn_weight,
    input  scan_done, busy
  );

  modport slave (
    input  spike_valid, spike_tag,
    input  cfg_valid, cfg_src, cfg_dst,
    input  cfg_weight, wm_weight_out,
    output spike_ready, cfg_ready,
    output wm_src_tag, wm_dst_tag,
    output wm_write_en, wm_weight_in,
    output syn_valid, syn_dst, syn_weight,
    output scan_done, busy
  );
endinterface

// File: rtl/efferent_weight_scheduler.sv
// Spike queue, destination scan and round-robin sharing of
// the weight-matrix port with host configuration writes.
module efferent_weight_scheduler #(
  parameter int N_NEURONS  = 2,
  parameter int TAG_W      = 1,
  parameter int WEIGHT_W   = 17,
  parameter int FIFO_DEPTH = 4
) (
  input logic clk,
  input logic reset_n,
  efferent_weight_scheduler_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [TAG_W-1:0] LAST =
    TAG_W'(N_NEURONS - 1);

  typedef enum logic [1:0] {
    IDLE, WRITE, SCAN, DRAIN
  } state_t;

  state_t           state;
  logic             prefer_spike;
  logic [TAG_W-1:0] fifo [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             cfg_hs;
  logic             s1_valid;
  logic             s1_last;
  logic [TAG_W-1:0] s1_dst;
  logic             keep;

  assign full  = count == (PTR_W+1)'(FIFO_DEPTH);
  assign empty = count == '0;
  assign bus.spike_ready = !full;
  assign bus.cfg_ready =
    (state == IDLE) && (empty || !prefer_spike);
  assign push   = bus.spike_valid && !full;
  assign cfg_hs = bus.cfg_valid && bus.cfg_ready;
  assign pop    = (state == IDLE) && !cfg_hs && !empty;
  assign bus.busy = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) fifo[wr_ptr] <= bus.spike_tag;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W+1)'(push)
                     - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      prefer_spike     <= 1'b0;
      bus.wm_src_tag   <= '0;
      bus.wm_dst_tag   <= '0;
      bus.wm_write_en  <= 1'b0;
      bus.wm_weight_in <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cfg_hs) begin
            state            <= WRITE;
            prefer_spike     <= 1'b1;
            bus.wm_src_tag   <= bus.cfg_src;
            bus.wm_dst_tag   <= bus.cfg_dst;
            bus.wm_weight_in <= bus.cfg_weight;
            bus.wm_write_en  <= 1'b1;
          end else if (!empty) begin
            state          <= SCAN;
            prefer_spike   <= 1'b0;
            bus.wm_src_tag <= fifo[rd_ptr];
            bus.wm_dst_tag <= '0;
          end
        end
        WRITE: begin
          state            <= IDLE;
          bus.wm_write_en  <= 1'b0;
          bus.wm_weight_in <= '0;
        end
        SCAN: begin
          if (bus.wm_dst_tag == LAST)
            state <= DRAIN;
          else
            bus.wm_dst_tag <= bus.wm_dst_tag + 1'b1;
        end
        DRAIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // +0 and -0 both carry no charge, so only magnitude counts
  assign keep = s1_valid &&
    (|bus.wm_weight_out[WEIGHT_W-2:0]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid       <= 1'b0;
      s1_last        <= 1'b0;
      s1_dst         <= '0;
      bus.syn_valid  <= 1'b0;
      bus.syn_dst    <= '0;
      bus.syn_weight <= '0;
      bus.scan_done  <= 1'b0;
    end else begin
      s1_valid       <= state == SCAN;
      s1_last        <= bus.wm_dst_tag == LAST;
      s1_dst         <= bus.wm_dst_tag;
      bus.syn_valid  <= keep;
      bus.syn_dst    <= keep ? s1_dst : '0;
      bus.syn_weight <= keep ? bus.wm_weight_out : '0;
      bus.scan_done  <= s1_valid && s1_last;
    end
  end
endmodule
